pb_bram_loader: RTL and testbench
=================================

Name: pb_bram_loader

Overview:
- Wishbone-attached control and program-load block for NUM_CORES PicoBlaze soft cores.
- Each core's instruction BRAM can be held in reset, written, read back and streamed with address auto-increment.
- Successor to the single-core reset/BRAM-write control register: adds per-core reset, core select, parametrised BRAM depth and read latency, auto-increment and a sticky error flag.
- Sits between the housekeeping Wishbone bus and the PicoBlaze instances, e.g. the I2C monitor core.

Parameters:
NUM_CORES, 2, number of PicoBlaze cores/BRAMs (1..8)
ADDR_BITS, 10, BRAM address width (instruction depth 2^ADDR_BITS)
READ_LATENCY, 1, BRAM read latency in clocks (1 or 2)
RESET_HOLD, 0, reset value of every pb_reset_o bit (1 = cores held in reset after wb_rst_i)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  12  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; ignored, full-word access only
wb_dat_o  out  32  read data
wb_ack_o  out  1  access acknowledge
pb_reset_o  out  NUM_CORES  per-core processor reset
bram_addr_o  out  ADDR_BITS  shared BRAM address
bram_data_o  out  18  shared BRAM write data
bram_we_o  out  NUM_CORES  one-hot, one-cycle BRAM write strobe
bram_rd_i  in  18*NUM_CORES  BRAM readback; core k at [18k+17:18k]

Behaviour:
Reset values:
- wb_ack_o=0, wb_dat_o=0, bram_we_o=0, bram_addr_o=0, bram_data_o=0.
- pb_reset_o = all RESET_HOLD.
- All register fields 0; FSM in IDLE.

Register map (wb_adr_i[3:2]):
- 0 CTRL:
  - [NUM_CORES-1:0] pb_reset
  - [10:8] core select (sel)
  - [30] auto-increment enable (ainc)
  - [31] write enable (wen)
- 1 ADDR:
  - [ADDR_BITS-1:0] BRAM address; upper bits write-ignored, read 0.
- 2 DATA:
  - Write: [17:0] BRAM write data.
  - Read: {14'b0, bram_rd_i slice of sel}.
- 3 STATUS:
  - [0] sticky error (wo1c)
  - [23:16] NUM_CORES
  - [27:24] ADDR_BITS
  - read-only except bit 0.

FSM:
- IDLE → ACCEPT on cyc&stb&!ack.
- Writes to CTRL/ADDR/STATUS: register updates on the accept edge; ack next cycle (1-cycle latency).
- DATA write is legal when wen=1, sel<NUM_CORES and pb_reset[sel]=1:
  - Accept edge: bram_data_o latched.
  - Next cycle: bram_we_o[sel]=1 for exactly one clock, coincident with ack.
  - If ainc=1, bram_addr_o increments the cycle after bram_we_o.
- Illegal DATA write: no bram_we_o, error bit set, ack still given, address unchanged.
- DATA read:
  - FSM waits READ_LATENCY cycles after accept, then samples bram_rd_i into wb_dat_o.
  - Ack comes READ_LATENCY+1 cycles after accept.
  - If ainc=1, address increments after the sample.
  - sel>=NUM_CORES: returns 0, sets error, no increment.
- Other reads: ack 1 cycle after accept.
- ack is high for one cycle only. A strobe held through ack is not re-accepted in the ack cycle; the next access is accepted no earlier than the cycle after ack falls.
- Address wrap: 2^ADDR_BITS-1 + 1 → 0, no error.
- cyc deasserted mid-read-wait: access completes internally (address increment still occurs) but ack is suppressed.
- Simultaneous ADDR write and pending increment cannot occur, because accesses are serialised.
- wb_rst_i mid-access (any state): return to IDLE next edge; ack and bram_we_o forced 0 that edge; registers take reset values.
- pb_reset_o is a direct register output; no glitches; changes only on CTRL write or reset.

Test Plan:
1. Reset with RESET_HOLD=0 → pb_reset_o=0, all outputs 0; STATUS read returns 0x0A020000 (NUM_CORES=2, ADDR_BITS=10).
2. CTRL=0xC0000102 (wen, ainc, sel=1, reset core1); ADDR=0x3FE; DATA writes 0x15A5A, 0x00001, 0x3FFFF → bram_we_o=2'b10 one cycle each at addresses 0x3FE, 0x3FF, 0x000; bram_addr_o ends at 0x001; STATUS[0]=0.
3. READ_LATENCY=2, ADDR=0x3FE, ainc=1, BRAM model with preloaded contents → three DATA reads return 0x15A5A, 0x00001, 0x3FFFF, each acked exactly 3 cycles after accept.
4. DATA write with pb_reset[sel]=0, then with sel=5 → no bram_we_o pulse, ack given, STATUS[0]=1; STATUS write 0x1 → STATUS[0]=0.
5. Assert wb_rst_i during the read wait of a DATA read → no ack, bram_addr_o=0, FSM accepts a new CTRL write 1 cycle after reset drops.
6. Back-to-back DATA writes with stb held high through ack → exactly one bram_we_o pulse per acked access, no duplicate write.

Source files
------------

// File: rtl/pb_bram_loader.sv
// rtl/pb_bram_loader.sv - Wishbone reset/program-load controller for NUM_CORES PicoBlaze instruction BRAMs
module pb_bram_loader #(
    parameter int NUM_CORES    = 2,
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 1,
    parameter int RESET_HOLD   = 0
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [11:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic [NUM_CORES-1:0]      pb_reset_o,
    output logic [ADDR_BITS-1:0]      bram_addr_o,
    output logic [17:0]               bram_data_o,
    output logic [NUM_CORES-1:0]      bram_we_o,
    input  logic [18*NUM_CORES-1:0]   bram_rd_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_WR,
        S_WR_INC,
        S_RD_WAIT
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [1:0] LAST_CNT   = 2'(READ_LATENCY - 1);
    localparam logic [7:0] NC8        = 8'(NUM_CORES);
    localparam logic [3:0] AB4        = 4'(ADDR_BITS);

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   pb_reset_q, pb_reset_d;
    logic [2:0]             sel_q, sel_d;
    logic                   ainc_q, ainc_d;
    logic                   wen_q, wen_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [17:0]            wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [NUM_CORES-1:0]   we_q, we_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   op_we_q, op_we_d;
    logic [1:0]             op_reg_q, op_reg_d;

    logic                   sel_valid;
    logic                   sel_rst;
    logic [17:0]            rd_slice;
    logic [NUM_CORES-1:0]   one_hot;
    logic [31:0]            reg_rdata;
    logic                   unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i, wb_dat_i};

    // Out-of-range core selects resolve to "invalid" instead of indexing past the buses.
    always_comb begin
        sel_valid = 1'b0;
        sel_rst   = 1'b0;
        rd_slice  = '0;
        one_hot   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (sel_q == 3'(k)) begin
                sel_valid  = 1'b1;
                sel_rst    = pb_reset_q[k];
                rd_slice   = bram_rd_i[18*k +: 18];
                one_hot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (op_reg_q)
            REG_CTRL:   reg_rdata = {wen_q, ainc_q, 19'b0, sel_q, 8'(pb_reset_q)};
            REG_ADDR:   reg_rdata = 32'(addr_q);
            REG_STATUS: reg_rdata = {4'b0, AB4, NC8, 15'b0, err_q};
            default:    reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pb_reset_d = pb_reset_q;
        sel_d      = sel_q;
        ainc_d     = ainc_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        we_d       = '0;
        ack_d      = 1'b0;
        dat_d      = dat_q;
        cnt_d      = cnt_q;
        op_we_d    = op_we_q;
        op_reg_d   = op_reg_q;

        case (state_q)
            S_IDLE: begin
                // ack_q blocks re-acceptance of a strobe still held through the ack cycle.
                if (wb_cyc_i && wb_stb_i && !ack_q) begin
                    op_we_d  = wb_we_i;
                    op_reg_d = wb_adr_i[3:2];
                    cnt_d    = '0;
                    state_d  = S_RESP;
                    if (wb_we_i) begin
                        case (wb_adr_i[3:2])
                            REG_CTRL: begin
                                pb_reset_d = wb_dat_i[NUM_CORES-1:0];
                                sel_d      = wb_dat_i[10:8];
                                ainc_d     = wb_dat_i[30];
                                wen_d      = wb_dat_i[31];
                            end
                            REG_ADDR: addr_d = wb_dat_i[ADDR_BITS-1:0];
                            REG_DATA: begin
                                wdata_d = wb_dat_i[17:0];
                                if (wen_q && sel_valid && sel_rst) begin
                                    state_d = S_WR;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: begin
                                if (wb_dat_i[0]) begin
                                    err_d = 1'b0;
                                end
                            end
                        endcase
                    end else if (wb_adr_i[3:2] == REG_DATA) begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RESP: begin
                ack_d = wb_cyc_i;
                if (!op_we_q && op_reg_q != REG_DATA) begin
                    dat_d = reg_rdata;
                end
                state_d = S_IDLE;
            end
            S_WR: begin
                we_d    = one_hot;
                ack_d   = wb_cyc_i;
                state_d = S_WR_INC;
            end
            S_WR_INC: begin
                if (ainc_q) begin
                    addr_d = addr_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    if (sel_valid) begin
                        dat_d = {14'b0, rd_slice};
                        if (ainc_q) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        dat_d = '0;
                        err_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            pb_reset_q <= {NUM_CORES{RESET_HOLD[0]}};
            sel_q      <= '0;
            ainc_q     <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            we_q       <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            cnt_q      <= '0;
            op_we_q    <= 1'b0;
            op_reg_q   <= '0;
        end else begin
            state_q    <= state_d;
            pb_reset_q <= pb_reset_d;
            sel_q      <= sel_d;
            ainc_q     <= ainc_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            we_q       <= we_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            cnt_q      <= cnt_d;
            op_we_q    <= op_we_d;
            op_reg_q   <= op_reg_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign pb_reset_o  = pb_reset_q;
    assign bram_addr_o = addr_q;
    assign bram_data_o = wdata_q;
    assign bram_we_o   = we_q;

endmodule

// File: tb/tb_pb_bram_loader.sv
// tb/tb_pb_bram_loader.sv - directed plus randomized bench for pb_bram_loader against a register/memory model
module tb_pb_bram_loader;

    localparam int NC = 2;
    localparam int AB = 10;
    localparam int RL = 2;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cyc, stb, we;
    logic [11:0]       adr;
    logic [31:0]       dat_i;
    logic [3:0]        bsel;
    logic [31:0]       dat_o;
    logic              ack;
    logic [NC-1:0]     pb_rst;
    logic [AB-1:0]     baddr;
    logic [17:0]       bdata;
    logic [NC-1:0]     bwe;
    logic [18*NC-1:0]  brd;

    pb_bram_loader #(
        .NUM_CORES(NC), .ADDR_BITS(AB), .READ_LATENCY(RL), .RESET_HOLD(0)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(bsel),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .pb_reset_o(pb_rst),
        .bram_addr_o(baddr), .bram_data_o(bdata), .bram_we_o(bwe), .bram_rd_i(brd)
    );

    function automatic logic [17:0] init_val(input int k, input int a);
        return 18'((a * 263 + k * 4099 + 17) ^ (a << 5));
    endfunction

    // BRAM environment: write on strobe, two-stage registered read.
    logic [17:0] bram_mem [NC][DEPTH];
    logic [17:0] rd_p1 [NC];
    logic [17:0] rd_p2 [NC];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int k = 0; k < NC; k++)
                for (int a = 0; a < DEPTH; a++)
                    bram_mem[k][a] = init_val(k, a);
            loaded = 1'b1;
        end
        for (int k = 0; k < NC; k++) begin
            rd_p2[k] <= rd_p1[k];
            rd_p1[k] <= bram_mem[k][baddr];
            if (bwe[k]) bram_mem[k][baddr] = bdata;
        end
    end
    assign brd = {rd_p2[1], rd_p2[0]};

    logic [31:0] we_log[$];
    always @(negedge clk) if (bwe != '0) we_log.push_back({2'b0, bwe, baddr, bdata});

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [17:0]   ref_mem [NC][DEPTH];
    logic [AB-1:0] ref_addr;
    logic          ref_err;
    logic [NC-1:0] ref_rst;
    logic [2:0]    ref_sel;
    logic          ref_ainc, ref_wen;

    task automatic model_reset();
        ref_addr = '0; ref_err = 1'b0; ref_rst = '0;
        ref_sel = '0; ref_ainc = 1'b0; ref_wen = 1'b0;
    endtask

    task automatic xfer(input bit nowait, input logic w, input logic [1:0] r, input logic [31:0] wd,
                        input int exp_lat, input logic [NC-1:0] exp_we, output logic [31:0] rd);
        bit got = 1'b0;
        if (!nowait) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {8'h0, r, 2'b00}; dat_i = wd;
        rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                chk("ack_latency", 32'(k - 1), 32'(exp_lat));
                chk("we_at_ack", 32'(bwe), 32'(exp_we));
                rd = dat_o;
                break;
            end
        end
        chk("acked", 32'(got), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        logic [31:0] rd;
        xfer(1'b0, 1'b1, 2'd0, v, 1, '0, rd);
        ref_rst = v[NC-1:0]; ref_sel = v[10:8]; ref_ainc = v[30]; ref_wen = v[31];
    endtask

    task automatic wr_addr(input logic [31:0] v);
        logic [31:0] rd;
        xfer(1'b0, 1'b1, 2'd1, v, 1, '0, rd);
        ref_addr = v[AB-1:0];
    endtask

    task automatic wr_status(input logic [31:0] v);
        logic [31:0] rd;
        xfer(1'b0, 1'b1, 2'd3, v, 1, '0, rd);
        if (v[0]) ref_err = 1'b0;
    endtask

    task automatic wr_data(input logic [17:0] d);
        logic [31:0]   rd;
        logic [31:0]   rec;
        logic [NC-1:0] exp_we;
        bit            legal;
        legal = ref_wen && (ref_sel < NC) && ref_rst[ref_sel[0]];
        exp_we = legal ? NC'(1 << ref_sel) : '0;
        we_log.delete();
        xfer(1'b0, 1'b1, 2'd2, {14'b0, d}, 1, exp_we, rd);
        @(negedge clk);
        if (legal) begin
            chk("we_pulses", 32'(we_log.size()), 32'd1);
            rec = (we_log.size() > 0) ? we_log[0] : '0;
            chk("we_record", rec, {2'b0, exp_we, ref_addr, d});
            ref_mem[ref_sel[0]][ref_addr] = d;
            if (ref_ainc) ref_addr = ref_addr + 1'b1;
        end else begin
            chk("we_pulses_illegal", 32'(we_log.size()), 32'd0);
            ref_err = 1'b1;
        end
        chk("bram_addr_after_wr", 32'(baddr), 32'(ref_addr));
    endtask

    task automatic rd_data();
        logic [31:0] rd;
        logic [17:0] exp;
        exp = (ref_sel < NC) ? ref_mem[ref_sel[0]][ref_addr] : '0;
        xfer(1'b0, 1'b0, 2'd2, '0, RL + 1, '0, rd);
        chk("rdata", rd, {14'b0, exp});
        if (ref_sel >= NC) ref_err = 1'b1;
        else if (ref_ainc) ref_addr = ref_addr + 1'b1;
        @(negedge clk);
        chk("bram_addr_after_rd", 32'(baddr), 32'(ref_addr));
    endtask

    task automatic chk_regs();
        logic [31:0] rd;
        xfer(1'b0, 1'b0, 2'd3, '0, 1, '0, rd);
        chk("status", rd, {4'b0, 4'(AB), 8'(NC), 15'b0, ref_err});
        xfer(1'b0, 1'b0, 2'd1, '0, 1, '0, rd);
        chk("addr_reg", rd, 32'(ref_addr));
        xfer(1'b0, 1'b0, 2'd0, '0, 1, '0, rd);
        chk("ctrl_reg", rd, {ref_wen, ref_ainc, 19'b0, ref_sel, 6'b0, ref_rst});
        chk("pb_reset_o", 32'(pb_rst), 32'(ref_rst));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   rd;
        logic [AB-1:0] a0;
        logic [17:0]   d;
        logic [1:0]    rs;
        int            s, n, acks;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; bsel = 4'hF;
        for (int k = 0; k < NC; k++)
            for (int a = 0; a < DEPTH; a++)
                ref_mem[k][a] = init_val(k, a);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_we", 32'(bwe), 32'd0);
        chk("rst_addr", 32'(baddr), 32'd0);
        chk("rst_bdata", 32'(bdata), 32'd0);
        chk("rst_pb_reset", 32'(pb_rst), 32'd0);
        rst = 1'b0;

        xfer(1'b0, 1'b0, 2'd3, '0, 1, '0, rd);
        chk("status_id", rd, 32'h0A02_0000);
        chk_regs();

        wr_ctrl(32'hC000_0102);
        wr_addr(32'h3FE);
        wr_data(18'h15A5A);
        wr_data(18'h00001);
        wr_data(18'h3FFFF);
        chk("addr_end_wrap", 32'(baddr), 32'h001);
        chk_regs();

        wr_addr(32'h3FE);
        rd_data();
        rd_data();
        rd_data();

        wr_ctrl(32'hC000_0100);
        wr_data(18'h2AAAA);
        chk_regs();
        wr_status(32'h1);
        chk_regs();
        wr_ctrl(32'hC000_0503);
        wr_data(18'h12345);
        rd_data();
        chk_regs();
        wr_status(32'h1);
        chk_regs();

        wr_ctrl(32'hC000_0102);
        wr_addr(32'h123);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h008;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (6) begin @(negedge clk); if (ack) acks++; end
        chk("cyc_drop_no_ack", 32'(acks), 32'd0);
        ref_addr = ref_addr + 1'b1;
        chk("cyc_drop_addr_inc", 32'(baddr), 32'(ref_addr));

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h008;
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_addr", 32'(baddr), 32'd0);
        chk("midrst_we", 32'(bwe), 32'd0);
        rst = 1'b0;
        model_reset();
        xfer(1'b1, 1'b1, 2'd0, 32'hC000_0102, 1, '0, rd);
        ref_rst = 2'b10; ref_sel = 3'd1; ref_ainc = 1'b1; ref_wen = 1'b1;
        chk_regs();

        wr_addr(32'h3FD);
        a0 = ref_addr;
        d = 18'h0BEEF;
        we_log.delete();
        acks = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h008; dat_i = {14'b0, d};
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (acks == 4) break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_ack_count", 32'(acks), 32'd4);
        chk("held_pulse_count", 32'(we_log.size()), 32'(acks));
        for (int i = 0; i < we_log.size(); i++) begin
            chk("held_record", we_log[i], {2'b0, 2'b10, AB'(a0 + AB'(i)), d});
        end
        for (int i = 0; i < acks; i++) begin
            ref_mem[1][ref_addr] = d;
            ref_addr = ref_addr + 1'b1;
        end
        chk("held_addr", 32'(baddr), 32'(ref_addr));

        for (int it = 0; it < 16; it++) begin
            s = $urandom_range(0, 1);
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rs[s] = 1'b1;
            wr_ctrl({($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 19'b0, 3'(s), 6'b0, rs});
            a0 = AB'($urandom_range(0, DEPTH - 1));
            n = $urandom_range(1, 3);
            wr_addr(32'(a0));
            for (int j = 0; j < n; j++) wr_data(18'($urandom));
            wr_addr(32'(a0));
            for (int j = 0; j < n; j++) rd_data();
            if (it % 4 == 3) begin
                chk_regs();
                wr_status(32'h1);
            end
        end
        chk_regs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
